// File: rtl/if_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory handshake, decode-facing
// output register, and the stall/redirect controls that steer fetch.
// master = fetch unit, slave = its environment (memory + decode + branch).
interface if_fetch_unit_if;
    // Instruction-memory request/ack handshake
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Decode-facing IF/ID register and its back-pressure
    logic        stall;
    logic [31:0] npcout;
    logic [31:0] instrout;
    logic        validout;

    // Redirect from the branch-resolve stage
    logic        br_taken;
    logic [31:0] br_target;

    modport master (
        output imem_req, imem_addr, npcout, instrout, validout,
        input  imem_ack, imem_rdata, stall, br_taken, br_target
    );

    modport slave (
        input  imem_req, imem_addr, npcout, instrout, validout,
        output imem_ack, imem_rdata, stall, br_taken, br_target
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to
// instruction memory, presents {PC+4, instruction} to decode through an
// output register backed by a one-entry skid buffer, and flushes all
// fetch-side state on a branch redirect. A redirect that arrives while a
// request is still waiting for ack cannot retract that request, so the
// unit parks in DISCARD, swallows the stale ack, then fetches the target.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rstn,
    if_fetch_unit_if.master bus
);

    // Fetch FSM encoding
    localparam logic [1:0] ST_REQ     = 2'd0;  // request outstanding, skid empty
    localparam logic [1:0] ST_DISCARD = 2'd1;  // waiting to drop a stale ack
    localparam logic [1:0] ST_IDLE    = 2'd2;  // skid full, no request

    // Control state
    logic [1:0]  state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] redirect_pc, redirect_nxt;

    // Output register (what decode currently sees)
    logic [31:0] out_npc;
    logic [31:0] out_instr;
    logic        out_v;

    // Skid register (one instruction parked while decode stalls)
    logic [31:0] skid_npc;
    logic [31:0] skid_instr;
    logic        skid_v;

    // Per-cycle decisions shared by the register blocks
    logic        req_active;
    logic        accept;
    logic        consume;
    logic        out_free;
    logic        fetch_to_out;
    logic        fetch_to_skid;
    logic        drain_skid;
    logic [31:0] pc_inc;
    logic [31:0] target;

    // The request is a registered state decode, masked while reset is held
    // so memory never sees a request during reset.
    assign req_active = (state == ST_REQ) || (state == ST_DISCARD);
    assign bus.imem_req  = req_active && rstn;
    assign bus.imem_addr = pc;

    assign accept   = bus.imem_req && bus.imem_ack;
    assign consume  = out_v && !bus.stall;
    assign out_free = !out_v || consume;
    assign pc_inc   = pc + 32'd4;
    assign target   = bus.br_target & ~32'h0000_0003;

    assign bus.npcout   = out_npc;
    assign bus.instrout = out_instr;
    assign bus.validout = out_v;

    // Next-state, PC and data-routing decisions for this edge
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // through the case can leave a variable unassigned and infer a latch.
        state_nxt     = state;
        pc_nxt        = pc;
        redirect_nxt  = redirect_pc;
        fetch_to_out  = 1'b0;
        fetch_to_skid = 1'b0;
        drain_skid    = 1'b0;

        case (state)
            ST_REQ: begin
                if (bus.br_taken) begin
                    if (accept) begin
                        // Data for the old path is dropped; fetch target next.
                        pc_nxt = target;
                    end else begin
                        // Request cannot be withdrawn: remember the target.
                        redirect_nxt = target;
                        state_nxt    = ST_DISCARD;
                    end
                end else if (accept) begin
                    pc_nxt = pc_inc;
                    if (out_free) begin
                        fetch_to_out = 1'b1;
                    end else begin
                        fetch_to_skid = 1'b1;
                        state_nxt     = ST_IDLE;
                    end
                end
            end

            ST_DISCARD: begin
                if (accept) begin
                    pc_nxt    = bus.br_taken ? target : redirect_pc;
                    state_nxt = ST_REQ;
                end else if (bus.br_taken) begin
                    // Latest redirect wins while still waiting.
                    redirect_nxt = target;
                end
            end

            ST_IDLE: begin
                if (bus.br_taken) begin
                    pc_nxt    = target;
                    state_nxt = ST_REQ;
                end else if (consume && skid_v) begin
                    drain_skid = 1'b1;
                    state_nxt  = ST_REQ;
                end
            end

            default: begin
                state_nxt = ST_REQ;
            end
        endcase
    end

    // FSM, PC and pending-redirect registers
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // always_ff samples pre-edge values regardless of evaluation order.
        if (!rstn) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            redirect_pc <= 32'h0000_0000;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            redirect_pc <= redirect_nxt;
        end
    end

    // Output register: redirect flush beats any load, then fetch/skid loads,
    // then plain consumption empties it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_npc   <= 32'h0000_0000;
            out_instr <= 32'h0000_0000;
            out_v     <= 1'b0;
        end else if (bus.br_taken) begin
            out_v <= 1'b0;
        end else if (fetch_to_out) begin
            out_npc   <= pc_inc;
            out_instr <= bus.imem_rdata;
            out_v     <= 1'b1;
        end else if (drain_skid) begin
            out_npc   <= skid_npc;
            out_instr <= skid_instr;
            out_v     <= 1'b1;
        end else if (consume) begin
            out_v <= 1'b0;
        end
    end

    // Skid valid flag: set on a fetch that found the output busy, cleared
    // when it drains into the output register or a redirect flushes it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            skid_v <= 1'b0;
        end else if (bus.br_taken) begin
            skid_v <= 1'b0;
        end else if (fetch_to_skid) begin
            skid_v <= 1'b1;
        end else if (drain_skid) begin
            skid_v <= 1'b0;
        end
    end

    // Skid payload capture
    always_ff @(posedge clk) begin
        // NOTE: the payload has no reset; it is only ever read behind skid_v,
        // which is reset, so clearing it would add reset fan-out for nothing.
        if (fetch_to_skid) begin
            skid_npc   <= pc_inc;
            skid_instr <= bus.imem_rdata;
        end
    end

    // A parked instruction only exists while fetch is idle.
    a_skid_only_idle : assert property (
        @(posedge clk) disable iff (!rstn) skid_v |-> (state == ST_IDLE)
    );

    // An unacknowledged request keeps its address until ack.
    a_addr_stable : assert property (
        @(posedge clk) disable iff (!rstn)
        (bus.imem_req && !bus.imem_ack) |=> $stable(bus.imem_addr)
    );

endmodule
